pipeline_hazard_ctrl: RTL

//  Issue controller in front of the stage-1 decode register. Accepts 32-bit instructions over valid/ready.

---
 rtl/phc_pkg.sv | 27 ++
 rtl/pipeline_hazard_ctrl_if.sv | 35 +++
 rtl/phc_scoreboard.sv | 42 ++++
 rtl/pipeline_hazard_ctrl.sv | 120 ++++++++++++
 4 files changed

// File: rtl/phc_pkg.sv
// Shared field positions, FSM states and scoreboard entry type for the hazard controller.
package phc_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned WS_HI   = 25;
    localparam int unsigned WS_LO   = 21;
    localparam int unsigned RS1_HI  = 20;
    localparam int unsigned RS1_LO  = 16;
    localparam int unsigned RS2_HI  = 15;
    localparam int unsigned RS2_LO  = 11;
    localparam int unsigned DS_BIT  = 29;
    localparam int unsigned FWD_W   = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    typedef struct packed {
        logic             v;
        logic [REG_W-1:0] ws;
    } sb_entry_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Instruction issue / drain / counter bundle; fwd_sel ports exist only with PHC_FORWARD_EN.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic                          instr_valid;
    logic [phc_pkg::INSTR_W-1:0]   instr_in;
    logic                          instr_ready;
    logic                          issue_valid;
    logic [phc_pkg::INSTR_W-1:0]   issue_instr;
    logic                          drain_req;
    logic                          drain_done;
    logic [CNT_W-1:0]              stall_cnt;
    logic [CNT_W-1:0]              issue_cnt;
`ifdef PHC_FORWARD_EN
    logic [phc_pkg::FWD_W-1:0]     fwd_sel1;
    logic [phc_pkg::FWD_W-1:0]     fwd_sel2;
`endif

    modport master (
        output instr_valid, instr_in, drain_req,
`ifdef PHC_FORWARD_EN
        input  fwd_sel1, fwd_sel2,
`endif
        input  instr_ready, issue_valid, issue_instr, drain_done, stall_cnt, issue_cnt
    );

    modport slave (
        input  instr_valid, instr_in, drain_req,
`ifdef PHC_FORWARD_EN
        output fwd_sel1, fwd_sel2,
`endif
        output instr_ready, issue_valid, issue_instr, drain_done, stall_cnt, issue_cnt
    );

endinterface

// File: rtl/phc_scoreboard.sv
// Shift register of in-flight write-selects with per-source match vectors.
module phc_scoreboard
    import phc_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [REG_W-1:0] ws_i,
    input  logic [REG_W-1:0] rs1_i,
    input  logic [REG_W-1:0] rs2_i,
    input  logic             ds_i,
    output logic [DEPTH-1:0] hit1_o,
    output logic [DEPTH-1:0] hit2_o,
    output logic             empty_o
);

    sb_entry_t sb_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(DEPTH); k++) sb_q[k] <= '0;
        end else begin
            sb_q[0] <= push_i ? sb_entry_t'({1'b1, ws_i}) : '0;
            for (int k = 1; k < int'(DEPTH); k++) sb_q[k] <= sb_q[k-1];
        end
    end

    // An immediate-form instruction has no RS2 operand, so it never matches there.
    always_comb begin
        hit1_o  = '0;
        hit2_o  = '0;
        empty_o = 1'b1;
        for (int k = 0; k < int'(DEPTH); k++) begin
            hit1_o[k] = sb_q[k].v && (sb_q[k].ws == rs1_i);
            hit2_o[k] = sb_q[k].v && (sb_q[k].ws == rs2_i) && !ds_i;
            if (sb_q[k].v) empty_o = 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Issue controller: RAW stall via scoreboard, drain FSM, stall/issue counters.
// Define PHC_FORWARD_EN to stall only on entry 0 and report forwarding sources instead.
module pipeline_hazard_ctrl
    import phc_pkg::*;
#(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave bus
);

    logic [REG_W-1:0]   ws, rs1, rs2;
    logic               ds;
    logic [DEPTH-1:0]   hit1, hit2;
    logic               sb_empty;
    logic               hazard;
    logic               ready_c;
    logic               accept;

    state_t             state_q;
    logic               issue_valid_q;
    logic [INSTR_W-1:0] issue_instr_q;
    logic               drain_done_q;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   issue_cnt_q;

    assign ws  = bus.instr_in[WS_HI:WS_LO];
    assign rs1 = bus.instr_in[RS1_HI:RS1_LO];
    assign rs2 = bus.instr_in[RS2_HI:RS2_LO];
    assign ds  = bus.instr_in[DS_BIT];

    phc_scoreboard #(.DEPTH(DEPTH)) u_sb (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .ws_i    (ws),
        .rs1_i   (rs1),
        .rs2_i   (rs2),
        .ds_i    (ds),
        .hit1_o  (hit1),
        .hit2_o  (hit2),
        .empty_o (sb_empty)
    );

`ifdef PHC_FORWARD_EN
    logic [FWD_W-1:0] fwd1_c, fwd2_c;
    logic [FWD_W-1:0] fwd1_q, fwd2_q;

    assign hazard = bus.instr_valid & (hit1[0] | hit2[0]);

    // Walk oldest to youngest so the youngest producer wins.
    always_comb begin
        fwd1_c = '0;
        fwd2_c = '0;
        for (int k = int'(DEPTH) - 1; k >= 1; k--) begin
            if (hit1[k]) fwd1_c = FWD_W'(k);
            if (hit2[k]) fwd2_c = FWD_W'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd1_q <= '0;
            fwd2_q <= '0;
        end else if (accept) begin
            fwd1_q <= fwd1_c;
            fwd2_q <= fwd2_c;
        end
    end

    assign bus.fwd_sel1 = fwd1_q;
    assign bus.fwd_sel2 = fwd2_q;
`else
    assign hazard = bus.instr_valid & |(hit1 | hit2);
`endif

    // A pending drain request wins over a same-cycle instruction, so ready drops with it.
    assign ready_c = (state_q == RUN) && !hazard && !bus.drain_req;
    assign accept  = bus.instr_valid && ready_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            issue_valid_q <= 1'b0;
            issue_instr_q <= '0;
            drain_done_q  <= 1'b0;
            stall_cnt_q   <= '0;
            issue_cnt_q   <= '0;
        end else begin
            issue_valid_q <= accept;
            drain_done_q  <= 1'b0;
            if (accept) begin
                issue_instr_q <= bus.instr_in;
                issue_cnt_q   <= issue_cnt_q + CNT_W'(1);
            end
            if (hazard && (state_q == RUN) && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            case (state_q)
                RUN:   if (bus.drain_req) state_q <= DRAIN;
                DRAIN: if (sb_empty) begin
                           state_q      <= DONE;
                           drain_done_q <= 1'b1;
                       end
                DONE:  state_q <= bus.drain_req ? HOLD : RUN;
                HOLD:  if (!bus.drain_req) state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.instr_ready = ready_c;
    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_instr = issue_instr_q;
    assign bus.drain_done  = drain_done_q;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.issue_cnt   = issue_cnt_q;

endmodule
